up_down_counter_param: RTL

- Parametrised successor to the team's 3-bit up/down counter.
- Rising-edge counter with the same 2-bit direction encoding (00/11 hold, 01 up, 10 down).
- Adds:
  - generic width and programmable [MIN_VALUE, MAX_VALUE] range;
  - wrap or saturate mode;
  - synchronous parallel load;
  - boundary flags, one-cycle overflow/underflow event pulses and sticky error flags.
- Used as a general event/position counter inside datapath controllers.

---
 rtl/up_down_counter_param_pkg.sv | 23 ++
 rtl/up_down_counter_param_if.sv | 28 ++
 rtl/up_down_counter_param_udc_next_value.sv | 68 ++++++
 rtl/up_down_counter_param.sv | 71 +++++++
 4 files changed

// File: rtl/up_down_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter: direction
// encoding and the elaboration-time parameter sanity check.
package counter_pkg;

   typedef enum logic [1:0] {
      UD_HOLD0 = 2'b00,
      UD_UP    = 2'b01,
      UD_DOWN  = 2'b10,
      UD_HOLD1 = 2'b11
   } ud_dir_t;

   // True when the width is usable and MIN <= RESET <= MAX < 2**WIDTH.
   function automatic bit params_ok(input int     width,
                                    input longint min_v,
                                    input longint max_v,
                                    input longint rst_v);
      return (width >= 2) && (width <= 32) &&
             (min_v >= 0) && (min_v <= max_v) &&
             (max_v < (longint'(1) << width)) &&
             (rst_v >= min_v) && (rst_v <= max_v);
   endfunction

endpackage

// File: rtl/up_down_counter_param_if.sv
// Control/status bundle of the counter; master drives the controls,
// slave (the counter) drives count and flags.
interface up_down_counter_param_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       up_dwn;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             sat_mode;
   logic             clear_flags;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_min;
   logic             ovf_pulse;
   logic             unf_pulse;
   logic             ovf_sticky;
   logic             unf_sticky;

   modport master (
      output up_dwn, load, load_value, sat_mode, clear_flags,
      input  count, at_max, at_min, ovf_pulse, unf_pulse, ovf_sticky, unf_sticky
   );

   modport slave (
      input  up_dwn, load, load_value, sat_mode, clear_flags,
      output count, at_max, at_min, ovf_pulse, unf_pulse, ovf_sticky, unf_sticky
   );
endinterface

// File: rtl/up_down_counter_param_udc_next_value.sv
// Combinational next-count logic: load clamping, step with wrap/saturate
// and overflow/underflow event detection.
module udc_next_value
   import counter_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MIN_C = '0,
   parameter logic [WIDTH-1:0] MAX_C = '1
) (
   input  logic [WIDTH-1:0] count,
   input  logic [1:0]       up_dwn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] next_count,
   output logic             ovf_evt,
   output logic             unf_evt
);
   logic below_min;
   logic above_max;

   // Clamp comparators only exist when the range is narrower than the word.
   if (MIN_C != '0) begin : g_lo_clamp
      assign below_min = (load_value < MIN_C);
   end else begin : g_no_lo_clamp
      assign below_min = 1'b0;
   end

   if (MAX_C != '1) begin : g_hi_clamp
      assign above_max = (load_value > MAX_C);
   end else begin : g_no_hi_clamp
      assign above_max = 1'b0;
   end

   always_comb begin
      next_count = count;
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;
      if (load) begin
         if (below_min)
            next_count = MIN_C;
         else if (above_max)
            next_count = MAX_C;
         else
            next_count = load_value;
      end else begin
         case (up_dwn)
            UD_UP: begin
               if (count == MAX_C) begin
                  ovf_evt    = 1'b1;
                  next_count = sat_mode ? count : MIN_C;
               end else begin
                  next_count = count + 1'b1;
               end
            end
            UD_DOWN: begin
               if (count == MIN_C) begin
                  unf_evt    = 1'b1;
                  next_count = sat_mode ? count : MAX_C;
               end else begin
                  next_count = count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with programmable range, wrap/saturate,
// parallel load, boundary flags, event pulses and sticky error flags.
module up_down_counter_param
   import counter_pkg::*;
#(
   parameter int     WIDTH       = 8,
   parameter longint MIN_VALUE   = 0,
   parameter longint MAX_VALUE   = (longint'(1) << WIDTH) - 1,
   parameter longint RESET_VALUE = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   up_down_counter_param_if.slave         bus
);
   localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);

   if (!params_ok(WIDTH, MIN_VALUE, MAX_VALUE, RESET_VALUE)) begin : g_param_error
      $error("up_down_counter_param: illegal WIDTH/MIN_VALUE/MAX_VALUE/RESET_VALUE");
   end

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             ovf_evt;
   logic             unf_evt;
   logic             ovf_pulse_reg;
   logic             unf_pulse_reg;
   logic             ovf_sticky_reg;
   logic             unf_sticky_reg;

   udc_next_value #(
      .WIDTH (WIDTH),
      .MIN_C (MIN_C),
      .MAX_C (MAX_C)
   ) u_next (
      .count      (count_reg),
      .up_dwn     (bus.up_dwn),
      .load       (bus.load),
      .load_value (bus.load_value),
      .sat_mode   (bus.sat_mode),
      .next_count (count_next),
      .ovf_evt    (ovf_evt),
      .unf_evt    (unf_evt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg      <= RST_C;
         ovf_pulse_reg  <= 1'b0;
         unf_pulse_reg  <= 1'b0;
         ovf_sticky_reg <= 1'b0;
         unf_sticky_reg <= 1'b0;
      end else begin
         count_reg      <= count_next;
         ovf_pulse_reg  <= ovf_evt;
         unf_pulse_reg  <= unf_evt;
         // A new event wins over a simultaneous clear request.
         ovf_sticky_reg <= ovf_evt | (ovf_sticky_reg & ~bus.clear_flags);
         unf_sticky_reg <= unf_evt | (unf_sticky_reg & ~bus.clear_flags);
      end
   end

   assign bus.count      = count_reg;
   assign bus.at_max     = (count_reg == MAX_C);
   assign bus.at_min     = (count_reg == MIN_C);
   assign bus.ovf_pulse  = ovf_pulse_reg;
   assign bus.unf_pulse  = unf_pulse_reg;
   assign bus.ovf_sticky = ovf_sticky_reg;
   assign bus.unf_sticky = unf_sticky_reg;
endmodule
